// File: rtl/argmax_seq_ctrl_if.sv
// Handshake bundle for argmax_seq_ctrl: score stream in, winning index out.
interface argmax_seq_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int DIM    = 10
);
  localparam int IDX_W = $clog2(DIM);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [IDX_W-1:0]         out_idx;
  logic                     out_err;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_idx, out_err
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_idx, out_err
  );
endinterface

// File: rtl/argmax_seq_ctrl.sv
// Streaming argmax over frames of up to DIM signed scores, with framing-error flag.
// Optional max_val output enabled by defining ARGMAX_MAXVAL_OUT_EN.
module argmax_seq_ctrl #(
  parameter int DATA_W = 32,
  parameter int DIM    = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  argmax_seq_ctrl_if.slave         bus,
  output logic                     busy
`ifdef ARGMAX_MAXVAL_OUT_EN
  ,
  output logic signed [DATA_W-1:0] max_val
`endif
);
  localparam int IDX_W = $clog2(DIM);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DIM - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [IDX_W-1:0]         cur_idx;
  logic signed [DATA_W-1:0] cur_max;
  logic                     err_q;

  logic acc, at_cap, term, frame_err;

  assign acc    = bus.in_valid && bus.in_ready;
  // beat index is 0 in IDLE and cnt in ACCUM; DIM >= 2 so IDLE never hits the cap
  assign at_cap = (state == ACCUM) && (cnt == LAST_BEAT);
  assign term   = bus.in_last || at_cap;
  assign frame_err = bus.in_last ? !at_cap : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      cur_idx <= '0;
      cur_max <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          cur_max <= bus.in_data;
          cur_idx <= '0;
          cnt     <= CNT_W'(1);
          if (term) begin
            err_q <= frame_err;
            state <= DONE;
          end else begin
            state <= ACCUM;
          end
        end
        ACCUM: if (acc) begin
          // strict compare: ties keep the earlier index
          if (bus.in_data > cur_max) begin
            cur_max <= bus.in_data;
            cur_idx <= cnt[IDX_W-1:0];
          end
          cnt <= cnt + CNT_W'(1);
          if (term) begin
            err_q <= frame_err;
            state <= DONE;
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // all outputs decode registered state only
  assign bus.in_ready  = (state != DONE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_idx   = cur_idx;
  assign bus.out_err   = err_q;
  assign busy          = (state != IDLE);

`ifdef ARGMAX_MAXVAL_OUT_EN
  assign max_val = cur_max;
`endif
endmodule

// File: tb/tb_argmax_seq_ctrl.sv
// Directed bench for argmax_seq_ctrl: driver pushes expectations, monitor pops on handshake.
module tb_argmax_seq_ctrl;
  localparam int DATA_W = 32;
  localparam int DIM    = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
`ifdef ARGMAX_MAXVAL_OUT_EN
  logic signed [DATA_W-1:0] max_val;
`endif

  argmax_seq_ctrl_if #(.DATA_W(DATA_W), .DIM(DIM)) bus ();

  argmax_seq_ctrl #(.DATA_W(DATA_W), .DIM(DIM)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
`ifdef ARGMAX_MAXVAL_OUT_EN
    ,
    .max_val (max_val)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int err;
    int mx;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   sc[$];

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // monitor: compare every completed output handshake against the scoreboard
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: result idx %0d with empty scoreboard", bus.out_idx);
      end else begin
        mon_e = sb.pop_front();
        chk("out_idx", bus.out_idx, mon_e.idx);
        chk("out_err", bus.out_err, mon_e.err);
`ifdef ARGMAX_MAXVAL_OUT_EN
        chk("max_val", max_val, mon_e.mx);
`endif
      end
    end
  end

  task automatic beat(input int d, input logic last);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!bus.in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL beat_timeout: in_ready stuck at 0, required 1");
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic last_flag, input int ei, input int ee, input int em,
                            input bit push, input bit gaps);
    exp_t e;
    if (push) begin
      e.idx = ei; e.err = ee; e.mx = em;
      sb.push_back(e);
    end
    for (int i = 0; i < sc.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      beat(sc[i], last_flag && (i == sc.size() - 1));
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("latency_out_valid", bus.out_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_idx", bus.out_idx, 0);
    chk("rst_out_err", bus.out_err, 0);
`ifdef ARGMAX_MAXVAL_OUT_EN
    chk("rst_max_val", max_val, 0);
`endif

    sc = '{3, -5, 7, 2, 9, 9, 0, -1, 4, 8};
    send_frame(1'b1, 4, 0, 9, 1'b1, 1'b0);
    sc = '{-100, -99, -98, -97, -96, -95, -94, -93, -92, -91};
    send_frame(1'b1, 9, 0, -91, 1'b1, 1'b0);
    sc = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
    send_frame(1'b1, 0, 0, 5, 1'b1, 1'b0);
    // ten beats without in_last: capped frame, flagged
    sc = '{0, 1, 2, 3, 4, 5, 6, 7, 8, -3};
    send_frame(1'b0, 8, 1, 8, 1'b1, 1'b0);
    sc = '{42};
    send_frame(1'b1, 0, 1, 42, 1'b1, 1'b0);

    // consumer stall while the next frame's first beat waits on the bus
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    sc = '{1, 6, 2, 3};
    send_frame(1'b1, 1, 1, 6, 1'b1, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = -7;
    bus.in_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_out_idx", bus.out_idx, 1);
      chk("stall_out_err", bus.out_err, 1);
      @(posedge clk); #1;
    end
    e.idx = 2; e.err = 1; e.mx = 9;
    sb.push_back(e);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bubble_in_ready", bus.in_ready, 1);
    chk("bubble_out_valid", bus.out_valid, 0);
    chk("bubble_busy", busy, 0);
    @(posedge clk); #1;
    chk("bubble_accept_busy", busy, 1);
    beat(4, 1'b0);
    beat(9, 1'b1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("stall_next_latency", bus.out_valid, 1);

    // back-to-back frames with random input gaps
    sc = '{12, -4, 30, 30, 1};
    send_frame(1'b1, 2, 1, 30, 1'b1, 1'b1);
    sc = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10};
    send_frame(1'b1, 0, 0, -1, 1'b1, 1'b1);
    sc = '{2, 4, 6, 1, 7, 7, 3, 0, 7, 5};
    send_frame(1'b1, 4, 0, 7, 1'b1, 1'b1);

    // reset after the sixth beat discards the partial frame
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) beat(20 + i, 1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_busy", busy, 0);
    sc = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    send_frame(1'b1, 3, 0, 1, 1'b1, 1'b0);

    // reset while a result is pending in DONE
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    sc = '{7, 8};
    send_frame(1'b1, 1, 1, 8, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("donerst_out_valid", bus.out_valid, 0);
    chk("donerst_busy", busy, 0);
    chk("donerst_out_err", bus.out_err, 0);
    bus.out_ready = 1'b1;

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
